// File: rtl/monitor_temperatura_multicanal.sv
// Multichannel temperature monitor: debounced per-channel trip, hysteresis clear, operator ack,
// first-out capture and saturating event count. Build option: AUTOLIMPA_EN (auto-rearm from ALARME).
module monitor_temperatura_multicanal #(
   parameter int N_CH       = 7,
   parameter int WIDTH      = 9,
   parameter int DEB_CYCLES = 3,
   parameter int HYST       = 5,
   parameter int EVT_W      = 8,
   localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    amostra_valida,
   input  logic [N_CH*WIDTH-1:0]   sensTemp,
   input  logic [N_CH*WIDTH-1:0]   limiar,
   input  logic [N_CH-1:0]         reconhecer,
   output logic [N_CH-1:0]         alarmeAtivo,
   output logic                    alarmeSonoroTemperatura,
   output logic [CW-1:0]           canalPrimeiro,
   output logic                    primeiroValido,
   output logic [EVT_W-1:0]        contEventos,
   output logic [2*N_CH-1:0]       o_dbg_estado
);

   localparam int DW = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {
      NORMAL      = 2'd0,
      PENDENTE    = 2'd1,
      ALARME      = 2'd2,
      RECONHECIDO = 2'd3
   } estado_t;

   estado_t          r_est [N_CH];
   logic [DW-1:0]    r_cnt [N_CH];
   logic [CW-1:0]    r_first;
   logic             r_first_v;
   logic [EVT_W-1:0] r_evt;

   logic [DW-1:0]    w_cnt_inc [N_CH];
   logic [N_CH-1:0]  w_over;
   logic [N_CH-1:0]  w_clr;
   logic [N_CH-1:0]  w_trip;
   logic [N_CH-1:0]  w_sai;
   logic [N_CH-1:0]  w_ativo;
   logic [N_CH-1:0]  w_ativo_prox;
   logic [N_CH-1:0]  w_sonoro;
   logic [CW-1:0]    w_first_idx;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [WIDTH-1:0] w_temp;
      logic [WIDTH-1:0] w_lim;
      logic [WIDTH-1:0] w_clr_lvl;

      assign w_temp    = sensTemp[g*WIDTH +: WIDTH];
      assign w_lim     = limiar[g*WIDTH +: WIDTH];
      // Clear level saturates at 0, so a threshold below HYST can never clear on temperature.
      assign w_clr_lvl = (w_lim >= WIDTH'(HYST)) ? (w_lim - WIDTH'(HYST)) : '0;
      assign w_over[g] = (w_temp >= w_lim);
      assign w_clr[g]  = (w_temp < w_clr_lvl);

      // NORMAL always holds cnt=0, so one compare covers both the DEB_CYCLES==1 and pending paths.
      assign w_cnt_inc[g] = r_cnt[g] + 1'b1;
      assign w_trip[g]    = amostra_valida & w_over[g] &
                            ((r_est[g] == NORMAL) || (r_est[g] == PENDENTE)) &
                            (w_cnt_inc[g] == DW'(DEB_CYCLES));
`ifdef AUTOLIMPA_EN
      assign w_sai[g] = amostra_valida & w_clr[g] &
                        ((r_est[g] == ALARME) || (r_est[g] == RECONHECIDO));
`else
      assign w_sai[g] = amostra_valida & w_clr[g] & (r_est[g] == RECONHECIDO);
`endif
      assign w_ativo[g]      = (r_est[g] == ALARME) || (r_est[g] == RECONHECIDO);
      assign w_ativo_prox[g] = (w_ativo[g] & ~w_sai[g]) | w_trip[g];
      assign w_sonoro[g]     = (r_est[g] == ALARME);
      assign o_dbg_estado[2*g +: 2] = r_est[g];
   end

   always_comb begin
      w_first_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (w_trip[i]) w_first_idx = CW'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            r_est[i] <= NORMAL;
            r_cnt[i] <= '0;
         end
         r_first   <= '0;
         r_first_v <= 1'b0;
         r_evt     <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            case (r_est[i])
               NORMAL, PENDENTE: begin
                  if (w_trip[i]) begin
                     r_est[i] <= ALARME;
                     r_cnt[i] <= '0;
                  end else if (amostra_valida && w_over[i]) begin
                     r_est[i] <= PENDENTE;
                     r_cnt[i] <= w_cnt_inc[i];
                  end else if (amostra_valida) begin
                     r_est[i] <= NORMAL;
                     r_cnt[i] <= '0;
                  end
               end
               ALARME: begin
                  if (w_sai[i])           r_est[i] <= NORMAL;
                  else if (reconhecer[i]) r_est[i] <= RECONHECIDO;
               end
               RECONHECIDO: begin
                  if (w_sai[i]) r_est[i] <= NORMAL;
               end
               default: r_est[i] <= NORMAL;
            endcase
         end

         // First-out is only captured when the plant was quiet before this edge.
         if (!(|w_ativo_prox)) begin
            r_first   <= '0;
            r_first_v <= 1'b0;
         end else if (!(|w_ativo) && (|w_trip)) begin
            r_first   <= w_first_idx;
            r_first_v <= 1'b1;
         end

         if ((|w_trip) && (r_evt != '1)) r_evt <= r_evt + 1'b1;
      end
   end

   assign alarmeAtivo             = w_ativo;
   assign alarmeSonoroTemperatura = |w_sonoro;
   assign canalPrimeiro           = r_first;
   assign primeiroValido          = r_first_v;
   assign contEventos             = r_evt;

endmodule

// File: tb/tb_monitor_temperatura_multicanal.sv
// Self-checking bench: directed scenarios plus randomized traffic against an episode-level model.
module tb_monitor_temperatura_multicanal;

   localparam int N_CH  = 7;
   localparam int WIDTH = 9;
   localparam int DEB   = 3;
   localparam int HYST  = 5;
   localparam int EVT_W = 4;
   localparam int CW    = 3;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  valid = 1'b0;
   logic [N_CH*WIDTH-1:0] sens = '0;
   logic [N_CH*WIDTH-1:0] lim = '0;
   logic [N_CH-1:0]       ack = '0;
   logic [N_CH-1:0]       ativo;
   logic                  sonoro;
   logic [CW-1:0]         primeiro;
   logic                  primeiro_v;
   logic [EVT_W-1:0]      cont;
   logic [2*N_CH-1:0]     dbg;

   monitor_temperatura_multicanal #(
      .N_CH(N_CH), .WIDTH(WIDTH), .DEB_CYCLES(DEB), .HYST(HYST), .EVT_W(EVT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .amostra_valida(valid), .sensTemp(sens), .limiar(lim),
      .reconhecer(ack), .alarmeAtivo(ativo), .alarmeSonoroTemperatura(sonoro),
      .canalPrimeiro(primeiro), .primeiroValido(primeiro_v), .contEventos(cont),
      .o_dbg_estado(dbg)
   );

   always #5 clk = ~clk;

   int t_arr [N_CH];
   int l_arr [N_CH];

   // Model: a channel is either quiet (counting a run of valid over-threshold samples)
   // or latched in an episode, optionally acknowledged.
   int  m_run [N_CH];
   bit  m_lat [N_CH];
   bit  m_ack [N_CH];
   int  m_first;
   bit  m_first_v;
   int  m_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_run[i] = 0;
         m_lat[i] = 0;
         m_ack[i] = 0;
      end
      m_first   = 0;
      m_first_v = 0;
      m_cnt     = 0;
   endtask

   task automatic model_step(input bit v, input logic [N_CH-1:0] a);
      bit was_any = 0;
      bit now_any = 0;
      int first_new = -1;
      for (int i = 0; i < N_CH; i++) if (m_lat[i]) was_any = 1;
      for (int i = 0; i < N_CH; i++) begin
         bit over;
         bit clr;
         int lvl;
         over = (t_arr[i] >= l_arr[i]);
         lvl  = (l_arr[i] >= HYST) ? l_arr[i] - HYST : 0;
         clr  = (t_arr[i] < lvl);
         if (!m_lat[i]) begin
            if (v) begin
               if (over) begin
                  m_run[i]++;
                  if (m_run[i] >= DEB) begin
                     m_lat[i] = 1;
                     m_ack[i] = 0;
                     m_run[i] = 0;
                     if (first_new < 0) first_new = i;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
         end else if (!m_ack[i]) begin
`ifdef AUTOLIMPA_EN
            if (v && clr) m_lat[i] = 0;
            else if (a[i]) m_ack[i] = 1;
`else
            if (a[i]) m_ack[i] = 1;
`endif
         end else if (v && clr) begin
            m_lat[i] = 0;
            m_ack[i] = 0;
         end
      end
      for (int i = 0; i < N_CH; i++) if (m_lat[i]) now_any = 1;
      if (!now_any) begin
         m_first   = 0;
         m_first_v = 0;
      end else if (!was_any && first_new >= 0) begin
         m_first   = first_new;
         m_first_v = 1;
      end
      if (first_new >= 0 && m_cnt < (2**EVT_W) - 1) m_cnt++;
   endtask

   task automatic check_outputs(input string tag);
      logic [N_CH-1:0] e_ativo;
      logic            e_son;
      e_ativo = '0;
      e_son   = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         e_ativo[i] = m_lat[i];
         if (m_lat[i] && !m_ack[i]) e_son = 1'b1;
      end
      check_eq({tag, ".ativo"},    32'(ativo),      32'(e_ativo));
      check_eq({tag, ".sonoro"},   32'(sonoro),     32'(e_son));
      check_eq({tag, ".primeiro"}, 32'(primeiro),   32'(m_first));
      check_eq({tag, ".prim_v"},   32'(primeiro_v), 32'(m_first_v));
      check_eq({tag, ".cont"},     32'(cont),       32'(m_cnt));
   endtask

   // Called on a falling edge: drive, let one rising edge capture, check on the next falling edge.
   task automatic cycle(input bit v, input logic [N_CH-1:0] a, input string tag);
      valid = v;
      ack   = a;
      for (int i = 0; i < N_CH; i++) begin
         sens[i*WIDTH +: WIDTH] = WIDTH'(t_arr[i]);
         lim[i*WIDTH +: WIDTH]  = WIDTH'(l_arr[i]);
      end
      @(posedge clk);
      model_step(v, a);
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs({tag, ".async"});
      @(negedge clk);
      rst_n = 1'b1;
      valid = 1'b0;
      ack   = '0;
      check_outputs({tag, ".rel"});
   endtask

   task automatic quiet();
      for (int i = 0; i < N_CH; i++) begin
         t_arr[i] = 100;
         l_arr[i] = 300;
      end
   endtask

   task automatic trip(input int ch, input string tag);
      t_arr[ch] = 305;
      repeat (DEB) cycle(1'b1, '0, tag);
      t_arr[ch] = 100;
   endtask

   int seq2 [6] = '{305, 305, 299, 305, 305, 305};

   initial begin
      quiet();
      model_reset();
      @(negedge clk);
      do_reset("rst0");

      // Debounce broken by one low sample, trips on the third consecutive one.
      for (int k = 0; k < 6; k++) begin
         t_arr[0] = seq2[k];
         cycle(1'b1, '0, "t2");
         if (k == 4) check_eq("t2.sonoro_before", 32'(sonoro), 32'd0);
      end
      check_eq("t2.sonoro_after", 32'(sonoro), 32'd1);
      check_eq("t2.cont", 32'(cont), 32'd1);
      check_eq("t2.primeiro", 32'(primeiro), 32'd0);
      check_eq("t2.prim_v", 32'(primeiro_v), 32'd1);

      // Asynchronous reset while in alarm.
      do_reset("t1");
      check_eq("t1.sonoro", 32'(sonoro), 32'd0);
      quiet();

      // Gaps between valid samples do not break the run.
      for (int k = 0; k < 3; k++) begin
         t_arr[0] = 305;
         cycle(1'b1, '0, "t3");
         if (k < 2) begin
            t_arr[0] = 0;
            cycle(1'b0, '0, "t3gap");
            cycle(1'b0, '0, "t3gap");
         end
      end
      check_eq("t3.sonoro", 32'(sonoro), 32'd1);
      t_arr[0] = 100;
      cycle(1'b0, N_CH'(1), "t3ack");
      cycle(1'b1, '0, "t3clr");

      // Acknowledge then hysteresis clear on channel 2.
      trip(2, "t4trip");
      cycle(1'b0, N_CH'(1 << 2), "t4ack");
      check_eq("t4.sonoro_ack", 32'(sonoro), 32'd0);
      check_eq("t4.ativo2_ack", 32'(ativo[2]), 32'd1);
      t_arr[2] = 295;
      cycle(1'b1, '0, "t4hold");
      check_eq("t4.ativo2_295", 32'(ativo[2]), 32'd1);
      t_arr[2] = 294;
      cycle(1'b1, '0, "t4clr");
      check_eq("t4.ativo2_294", 32'(ativo[2]), 32'd0);
      check_eq("t4.prim_v", 32'(primeiro_v), 32'd0);

      // Simultaneous trips on channels 1 and 4.
      t_arr[1] = 305;
      t_arr[4] = 305;
      repeat (DEB) cycle(1'b1, '0, "t5");
      check_eq("t5.primeiro", 32'(primeiro), 32'd1);
      check_eq("t5.cont", 32'(cont), 32'd3);
      t_arr[1] = 100;
      t_arr[4] = 100;
      cycle(1'b0, N_CH'(8'h12), "t5ack");
      cycle(1'b1, '0, "t5clr");

      // Temperature drop without acknowledge.
      trip(3, "t6trip");
      t_arr[3] = 250;
      cycle(1'b1, '0, "t6drop");
`ifdef AUTOLIMPA_EN
      check_eq("t6.ativo3", 32'(ativo[3]), 32'd0);
`else
      check_eq("t6.ativo3", 32'(ativo[3]), 32'd1);
`endif
      t_arr[3] = 100;
      cycle(1'b0, N_CH'(1 << 3), "t6ack");
      cycle(1'b1, '0, "t6clr");

      // Event counter saturation: 15 more episodes on top of the 4 so far.
      for (int k = 0; k < 15; k++) begin
         trip(0, "sat");
         cycle(1'b0, N_CH'(1), "satack");
         cycle(1'b1, '0, "satclr");
      end
      check_eq("sat.cont", 32'(cont), 32'((2**EVT_W) - 1));

      // Randomized traffic around the thresholds.
      do_reset("rnd_rst");
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < N_CH; i++) l_arr[i] = $urandom_range(250, 300);
         if (ph == 3) l_arr[$urandom_range(0, N_CH - 1)] = $urandom_range(0, HYST - 1);
         for (int c = 0; c < 100; c++) begin
            logic [N_CH-1:0] a;
            bit v;
            for (int i = 0; i < N_CH; i++) begin
               int t;
               t = l_arr[i] - 8 + int'($urandom_range(0, 16));
               if (t < 0) t = 0;
               t_arr[i] = t;
               a[i] = ($urandom_range(0, 7) == 0);
            end
            v = ($urandom_range(0, 3) != 0);
            cycle(v, a, "rnd");
            if (ph == 2 && c == 50) do_reset("rnd_mid");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
